mem_reg: RTL and testbench

//   Register-file storage for the Kalman filter datapath: a DEPTH-entry data bank

---
 rtl/mem_reg.sv | 106 ++++++++++
 tb/tb_mem_reg.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_reg.sv
// mem_reg: register-file storage for the Kalman filter datapath.
//   A DEPTH-entry data bank with one synchronous write port and two
//   combinational read ports (optional same-cycle write forwarding), plus
//   two standalone W-bit holding registers: RQ (process noise) and RD
//   (measurement noise).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   db_we, db_waddr, db_wdata       bank write port
//   db_raddr_a/b, db_rdata_a/b      bank read ports (combinational)
//   rq_we, rq_d, rq_q               RQ load enable, load data, value
//   rd_we, rd_d, rd_q               RD load enable, load data, value
module mem_reg #(
  parameter int W       = 24,
  parameter int DEPTH   = 40,
  parameter int ADDRW   = 6,
  parameter int FORWARD = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             db_we,
  input  logic [ADDRW-1:0] db_waddr,
  input  logic [W-1:0]     db_wdata,
  input  logic [ADDRW-1:0] db_raddr_a,
  input  logic [ADDRW-1:0] db_raddr_b,
  output logic [W-1:0]     db_rdata_a,
  output logic [W-1:0]     db_rdata_b,
  input  logic             rq_we,
  input  logic [W-1:0]     rq_d,
  output logic [W-1:0]     rq_q,
  input  logic             rd_we,
  input  logic [W-1:0]     rd_d,
  output logic [W-1:0]     rd_q
);

  // One extra bit so the bound compare works even when DEPTH == 2**ADDRW.
  localparam logic [ADDRW:0] DEPTH_X = (ADDRW+1)'(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [W-1:0] rq_reg_q, rq_reg_d;
  logic [W-1:0] rd_reg_q, rd_reg_d;
  logic         wr_ok;
  logic         fwd_a, fwd_b;
  logic [W-1:0] rdata_a, rdata_b;

  // A write only qualifies when it targets an existing entry.
  assign wr_ok = db_we && ({1'b0, db_waddr} < DEPTH_X);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_ok && (db_waddr == ADDRW'(i))) begin
        mem_d[i] = db_wdata;
      end
    end
    rq_reg_d = rq_we ? rq_d : rq_reg_q;
    rd_reg_d = rd_we ? rd_d : rd_reg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rq_reg_q <= '0;
      rd_reg_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rq_reg_q <= rq_reg_d;
      rd_reg_q <= rd_reg_d;
    end
  end

  // Read mux: an address past the last entry matches nothing and yields 0.
  // A qualified write to the same address overrides the stored word when
  // forwarding is enabled, so the consumer sees it before the edge.
  assign fwd_a = (FORWARD != 0) && wr_ok && (db_raddr_a == db_waddr);
  assign fwd_b = (FORWARD != 0) && wr_ok && (db_raddr_b == db_waddr);

  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (db_raddr_a == ADDRW'(i)) begin
        rdata_a = mem_q[i];
      end
      if (db_raddr_b == ADDRW'(i)) begin
        rdata_b = mem_q[i];
      end
    end
    if (fwd_a) begin
      rdata_a = db_wdata;
    end
    if (fwd_b) begin
      rdata_b = db_wdata;
    end
  end

  assign db_rdata_a = rdata_a;
  assign db_rdata_b = rdata_b;
  assign rq_q       = rq_reg_q;
  assign rd_q       = rd_reg_q;

endmodule

// File: tb/tb_mem_reg.sv
// tb_mem_reg: self-checking bench for mem_reg (W=24, DEPTH=40, ADDRW=6,
// FORWARD=1). A behavioural model (plain array plus two words) tracks the
// storage; a negedge process compares every output against it each cycle,
// and directed steps pin literal values.
module tb_mem_reg;

  localparam int W     = 24;
  localparam int DEPTH = 40;
  localparam int ADDRW = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             db_we;
  logic [ADDRW-1:0] db_waddr;
  logic [W-1:0]     db_wdata;
  logic [ADDRW-1:0] db_raddr_a;
  logic [ADDRW-1:0] db_raddr_b;
  logic [W-1:0]     db_rdata_a;
  logic [W-1:0]     db_rdata_b;
  logic             rq_we;
  logic [W-1:0]     rq_d;
  logic [W-1:0]     rq_q;
  logic             rd_we;
  logic [W-1:0]     rd_d;
  logic [W-1:0]     rd_q;

  mem_reg #(.W(W), .DEPTH(DEPTH), .ADDRW(ADDRW), .FORWARD(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .db_we      (db_we),
    .db_waddr   (db_waddr),
    .db_wdata   (db_wdata),
    .db_raddr_a (db_raddr_a),
    .db_raddr_b (db_raddr_b),
    .db_rdata_a (db_rdata_a),
    .db_rdata_b (db_rdata_b),
    .rq_we      (rq_we),
    .rq_d       (rq_d),
    .rq_q       (rq_q),
    .rd_we      (rd_we),
    .rd_d       (rd_d),
    .rd_q       (rd_q)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b0;

  // Behavioural model: whole address space, only the first DEPTH entries used.
  logic [W-1:0] m_mem [64];
  logic [W-1:0] m_rq = '0;
  logic [W-1:0] m_rd = '0;

  initial begin
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pat(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA5, b, 8'h5A};
  endfunction

  // Expected read value from the model, including same-cycle forwarding.
  function automatic logic [W-1:0] exp_rd(input logic [ADDRW-1:0] addr);
    int a;
    int wa;
    a  = int'(addr);
    wa = int'(db_waddr);
    if (a >= DEPTH) return '0;
    if (db_we && wa < DEPTH && wa == a) return db_wdata;
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m_mem[i] <= '0;
      m_rq <= '0;
      m_rd <= '0;
    end else begin
      if (db_we && int'(db_waddr) < DEPTH) m_mem[db_waddr] <= db_wdata;
      if (rq_we) m_rq <= rq_d;
      if (rd_we) m_rd <= rd_d;
    end
  end

  always @(negedge clk) begin
    if (run_cmp && rst_n) begin
      check("model_rdata_a", db_rdata_a, exp_rd(db_raddr_a));
      check("model_rdata_b", db_rdata_b, exp_rd(db_raddr_b));
      check("model_rq_q", rq_q, m_rq);
      check("model_rd_q", rd_q, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; db_we = 1'b0; db_waddr = '0; db_wdata = '0;
    db_raddr_a = '0; db_raddr_b = 6'd1;
    rq_we = 1'b0; rq_d = '0; rd_we = 1'b0; rd_d = '0;

    // Reset state.
    #2;
    check("reset_rdata_a", db_rdata_a, 24'h0);
    check("reset_rdata_b", db_rdata_b, 24'h0);
    check("reset_rq_q", rq_q, 24'h0);
    check("reset_rd_q", rd_q, 24'h0);
    #10 rst_n = 1'b1;
    run_cmp = 1'b1;

    // Fill then dual-port readback.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      db_we = 1'b1; db_waddr = ADDRW'(i); db_wdata = pat(i);
    end
    tick();
    db_we = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      db_raddr_a = ADDRW'(i);
      db_raddr_b = ADDRW'(DEPTH - 1 - i);
      #1;
      check("fill_rdata_a", db_rdata_a, pat(i));
      check("fill_rdata_b", db_rdata_b, pat(DEPTH - 1 - i));
      tick();
    end

    // Forwarding before the edge, then stored after it.
    db_we = 1'b1; db_waddr = 6'd3; db_wdata = 24'hDEADBE;
    db_raddr_a = 6'd3; db_raddr_b = 6'd2;
    #1;
    check("fwd_rdata_a", db_rdata_a, 24'hDEADBE);
    check("fwd_rdata_b", db_rdata_b, 24'hA5025A);
    tick();
    db_we = 1'b0;
    #1;
    check("fwd_stored", db_rdata_a, 24'hDEADBE);

    // Out-of-range write and read.
    tick();
    db_we = 1'b1; db_waddr = 6'd45; db_wdata = 24'h123456; db_raddr_a = 6'd45;
    #1;
    check("oor_read_during_write", db_rdata_a, 24'h0);
    tick();
    db_we = 1'b0;
    #1;
    check("oor_read", db_rdata_a, 24'h0);
    for (int i = 0; i < DEPTH; i++) begin
      db_raddr_b = ADDRW'(i);
      #1;
      check("oor_no_change", db_rdata_b, (i == 3) ? 24'hDEADBE : pat(i));
    end

    // RQ / RD load.
    tick();
    rq_we = 1'b1; rq_d = 24'h001111;
    tick();
    rq_we = 1'b0;
    check("rq_load", rq_q, 24'h001111);
    rd_we = 1'b1; rd_d = 24'h223333;
    tick();
    rd_we = 1'b0;
    check("rd_load", rd_q, 24'h223333);
    check("rq_kept", rq_q, 24'h001111);

    // Hold with enables low.
    rq_d = 24'hAABBCC; rd_d = 24'hCCDDEE;
    tick();
    tick();
    check("rq_hold", rq_q, 24'h001111);
    check("rd_hold", rd_q, 24'h223333);

    // Randomised traffic, checked by the model every cycle.
    for (int n = 0; n < 400; n++) begin
      tick();
      db_we      = ($urandom_range(3, 0) != 0);
      db_waddr   = ($urandom_range(7, 0) == 0) ? ADDRW'($urandom_range(63, DEPTH))
                                               : ADDRW'($urandom_range(DEPTH - 1, 0));
      db_wdata   = W'($urandom);
      db_raddr_a = ($urandom_range(3, 0) == 0) ? db_waddr : ADDRW'($urandom_range(63, 0));
      db_raddr_b = ($urandom_range(3, 0) == 0) ? db_waddr : ADDRW'($urandom_range(DEPTH, 0));
      rq_we      = ($urandom_range(3, 0) == 0);
      rq_d       = W'($urandom);
      rd_we      = ($urandom_range(3, 0) == 0);
      rd_d       = W'($urandom);
    end

    // Refill with a known nonzero pattern, then asynchronous reset mid-cycle.
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      db_we = 1'b1; db_waddr = ADDRW'(i); db_wdata = pat(i);
      rq_we = 1'b1; rq_d = 24'h0F0F0F; rd_we = 1'b1; rd_d = 24'hF0F0F0;
    end
    tick();
    db_we = 1'b0; rq_we = 1'b0; rd_we = 1'b0;
    db_raddr_a = 6'd0; db_raddr_b = 6'd1;
    #1;
    check("prereset_rdata_b", db_rdata_b, 24'hA5015A);
    rst_n = 1'b0;
    #1;
    check("areset_rdata_a", db_rdata_a, 24'h0);
    check("areset_rdata_b", db_rdata_b, 24'h0);
    check("areset_rq_q", rq_q, 24'h0);
    check("areset_rd_q", rd_q, 24'h0);
    db_raddr_a = 6'd39; db_raddr_b = 6'd20;
    #1;
    check("areset_rdata_a39", db_rdata_a, 24'h0);
    check("areset_rdata_b20", db_rdata_b, 24'h0);
    #1 rst_n = 1'b1;

    // Recovery traffic after reset.
    for (int n = 0; n < 50; n++) begin
      tick();
      db_we      = $urandom_range(1, 0) != 0;
      db_waddr   = ADDRW'($urandom_range(63, 0));
      db_wdata   = W'($urandom);
      db_raddr_a = ADDRW'($urandom_range(63, 0));
      db_raddr_b = db_waddr;
      rq_we      = $urandom_range(1, 0) != 0;
      rq_d       = W'($urandom);
      rd_we      = $urandom_range(1, 0) != 0;
      rd_d       = W'($urandom);
    end
    tick();
    db_we = 1'b0; rq_we = 1'b0; rd_we = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
